putchar_ctl: RTL
================

# putchar_ctl

Parametrised character writer for the serial terminal's text VRAM. Accepts bytes over a valid/ready handshake. Each byte is either written as a glyph at the cursor position or interpreted as a control code. The block then advances the cursor. When the cursor leaves the bottom row, it requests a scroll from the scroll module, waits for the scroll to finish, and blanks the new bottom line. It sits between the UART receive path and the VRAM write port, and owns the cursor instead of relying on an external position module.

## Interface
- COLS, 80: characters per row (2..256)
- ROWS, 30: rows on screen (2..256)
- ADDR_W, 12: VRAM address width; must satisfy 2^ADDR_W >= COLS*ROWS
- TAB_W, 8: tab stop spacing; must be a power of two
- BLANK, 8'h20: byte written when clearing a line
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active high
- i_valid  in  1  i_char is valid
- o_ready  out  1  block can accept a byte this cycle
- i_char  in  8  byte to print
- o_vram_ce  out  1  VRAM chip enable
- o_vram_w  out  1  VRAM write strobe
- o_vram_addr  out  ADDR_W  VRAM address, row*COLS+col
- o_vram_din  out  8  VRAM write data
- o_running  out  1  block owns the VRAM port this cycle
- o_scroll  out  1  scroll-up request, level-held
- i_scroll_done  in  1  one-cycle pulse from the scroll module: scroll complete
- o_col  out  8  cursor column
- o_row  out  8  cursor row

## Operation
- Reset values:
  - state IDLE
  - col = 0, row = 0
  - o_ready = 1
  - o_vram_ce, o_vram_w, o_running, o_scroll = 0
  - o_vram_addr = 0, o_vram_din = 0
- States:
  - IDLE: o_ready=1. On i_valid, latch i_char, then go to WRITE (printable byte) or CTRL (control code).
  - WRITE: one cycle with ce=w=running=1, addr = cursor, din = latched char. Then col+1. If col was COLS-1: col=0, row+1. If row was ROWS-1: keep row, go to SCROLL; otherwise go to IDLE.
  - CTRL: one cycle, no VRAM access.
    - CR (0x0D): col=0.
    - LF (0x0A): row+1; at ROWS-1 go to SCROLL, col unchanged.
    - BS (0x08): col-1, saturating at 0; no erase.
    - TAB (0x09): col advances to the next multiple of TAB_W, clamped at COLS-1; never wraps.
    - All other bytes below 0x20: ignored.
    - Returns to IDLE unless SCROLL was entered.
  - SCROLL: o_scroll=1, o_running=0, o_ready=0. Hold until i_scroll_done=1, then clear o_scroll and go to CLEAR with the clear counter = 0.
  - CLEAR: COLS consecutive write cycles, addr = (ROWS-1)*COLS + counter, din = BLANK, ce=w=running=1. After the last one, row=ROWS-1, col unchanged from before the scroll (0 after a wrap), then go to IDLE.
- Printable means i_char >= 0x20. Bytes 0x80..0xFF are printable (extended glyph ROM).
- Address arithmetic is unsigned and ADDR_W wide; row*COLS is computed as a constant-multiply, with no truncation for legal parameters.
- i_scroll_done outside SCROLL is ignored.
- Reset in any state aborts the operation immediately: a pending scroll request drops and a partial clear is abandoned. Both take effect the cycle after i_rst is sampled.

## Timing
- Accept: the byte is taken on the edge where i_valid & o_ready. o_ready drops the following cycle.
- Printable, no scroll: VRAM write on cycle N+1 after accept. Cursor updated and o_ready=1 on N+2. Throughput is 1 byte per 2 cycles.
- Control code: cursor updated on N+2, no write.
- Scroll path: o_scroll rises on N+2 and falls the cycle after i_scroll_done. CLEAR then occupies exactly COLS cycles, and o_ready returns the cycle after the last blank write.
- o_vram_w and o_vram_ce are asserted together, only when o_running=1.
- o_col and o_row are registered and change only at state exits.

## Configuration
- PUTCHAR_CTRL_EN defined: control-code interpretation as described under CTRL.
- PUTCHAR_CTRL_EN undefined: the CTRL state is removed. Every byte, including 0x00..0x1F, is written as a glyph via WRITE, and wrap/scroll behaviour is unchanged.

## Test plan
- Reset, then send 'A' (0x41) -> one write at addr 0 with din 0x41; o_col=1, o_row=0; o_ready high again 2 cycles after accept.
- Cursor at col=COLS-1, row=3, send 'Z' -> write at addr 3*COLS+COLS-1; then col=0, row=4; o_scroll stays 0.
- Cursor at (COLS-1, ROWS-1), send 'x' -> write at COLS*ROWS-1; o_scroll held until i_scroll_done, which arrives after 5 cycles. Then exactly COLS writes of 0x20 at (ROWS-1)*COLS..COLS*ROWS-1; final cursor (0, ROWS-1).
- With PUTCHAR_CTRL_EN, cursor at col=13: TAB -> 16; BS -> 15; CR -> 0; LF at row 2 -> row 3. No VRAM writes. Without the macro, the same bytes produce 4 writes.
- Assert i_rst during CLEAR, with the counter at 10 -> next cycle o_vram_w=0, o_scroll=0, cursor (0,0), o_ready=1.
- i_valid held high with 4 consecutive printable bytes -> accepts spaced 2 cycles apart; writes at addr 0..3 in order; no byte dropped or duplicated.

Source files
------------

// File: rtl/putchar_ctl.sv
// Character writer for the terminal text VRAM: glyph writes, control codes, scroll handshake, line blanking.
// Optional macro PUTCHAR_CTRL_EN enables control-code interpretation; otherwise every byte is a glyph.
module putchar_ctl #(
    parameter int          COLS   = 80,
    parameter int          ROWS   = 30,
    parameter int          ADDR_W = 12,
    parameter int          TAB_W  = 8,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [7:0]        i_char,
    output logic              o_vram_ce,
    output logic              o_vram_w,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic [7:0]        o_vram_din,
    output logic              o_running,
    output logic              o_scroll,
    input  logic              i_scroll_done,
    output logic [7:0]        o_col,
    output logic [7:0]        o_row
);

    if ((TAB_W < 1) || ((TAB_W & (TAB_W - 1)) != 0)) begin : g_bad_tab
        $error("putchar_ctl: TAB_W must be a power of two");
    end

    // state  | meaning
    // IDLE   | ready for a byte
    // WRITE  | one glyph write at the cursor
    // CTRL   | apply a control code to the cursor
    // SCROLL | scroll request held until done pulse
    // CLEAR  | blank the bottom row, one cell per cycle
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
`ifdef PUTCHAR_CTRL_EN
    localparam logic [2:0] S_CTRL   = 3'd2;
`endif
    localparam logic [2:0] S_SCROLL = 3'd3;
    localparam logic [2:0] S_CLEAR  = 3'd4;

    localparam logic [7:0]        COL_LAST = 8'(COLS - 1);
    localparam logic [7:0]        ROW_LAST = 8'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CLR_BASE = ADDR_W'((ROWS - 1) * COLS);

    logic [2:0] state_q, state_d;
    logic [7:0] col_q, col_d;
    logic [7:0] row_q, row_d;
    logic [7:0] char_q, char_d;
    logic [7:0] cnt_q, cnt_d;
    logic       is_print;
    logic [ADDR_W-1:0] addr_cur;

`ifdef PUTCHAR_CTRL_EN
    localparam logic [7:0] TAB_MASK = 8'(TAB_W - 1);
    localparam logic [8:0] TAB_STEP = 9'(TAB_W);
    logic [8:0] tab_raw;
    logic [7:0] tab_col;

    assign is_print = (i_char >= 8'h20);
    assign tab_raw  = {1'b0, col_q & ~TAB_MASK} + TAB_STEP;
    // Tab clamps at the right margin rather than wrapping to the next row.
    assign tab_col  = (tab_raw > {1'b0, COL_LAST}) ? COL_LAST : tab_raw[7:0];
`else
    assign is_print = 1'b1;
`endif

    assign addr_cur = ADDR_W'(row_q) * COLS_A + ADDR_W'(col_q);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        char_d  = char_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    char_d = i_char;
`ifdef PUTCHAR_CTRL_EN
                    state_d = is_print ? S_WRITE : S_CTRL;
`else
                    state_d = is_print ? S_WRITE : S_IDLE;
`endif
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                if (col_q == COL_LAST) begin
                    col_d = 8'd0;
                    if (row_q == ROW_LAST) state_d = S_SCROLL;
                    else                   row_d   = row_q + 8'd1;
                end else begin
                    col_d = col_q + 8'd1;
                end
            end
`ifdef PUTCHAR_CTRL_EN
            S_CTRL: begin
                state_d = S_IDLE;
                case (char_q)
                    8'h0D: col_d = 8'd0;
                    8'h0A: begin
                        if (row_q == ROW_LAST) state_d = S_SCROLL;
                        else                   row_d   = row_q + 8'd1;
                    end
                    8'h08: if (col_q != 8'd0) col_d = col_q - 8'd1;
                    8'h09: col_d = tab_col;
                    default: ;
                endcase
            end
`endif
            S_SCROLL: begin
                if (i_scroll_done) begin
                    state_d = S_CLEAR;
                    cnt_d   = 8'd0;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == COL_LAST) begin
                    state_d = S_IDLE;
                    row_d   = ROW_LAST;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            col_q   <= 8'd0;
            row_q   <= 8'd0;
            char_q  <= 8'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            char_q  <= char_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ready     = (state_q == S_IDLE);
    assign o_running   = (state_q == S_WRITE) || (state_q == S_CLEAR);
    assign o_vram_ce   = o_running;
    assign o_vram_w    = o_running;
    assign o_scroll    = (state_q == S_SCROLL);
    assign o_vram_addr = (state_q == S_WRITE) ? addr_cur :
                         (state_q == S_CLEAR) ? CLR_BASE + ADDR_W'(cnt_q) : '0;
    assign o_vram_din  = (state_q == S_WRITE) ? char_q :
                         (state_q == S_CLEAR) ? BLANK : 8'd0;
    assign o_col       = col_q;
    assign o_row       = row_q;

endmodule
